// File: rtl/board_generator_seq.sv
// Sequential board generator: fills a ROWS x COLS board of colour codes from a
// seedable 16-bit LFSR, nudging any colour that would complete a run of three.
module board_generator_seq #(
    parameter int          ROWS       = 8,
    parameter int          COLS       = 8,
    parameter int          CELL_W     = 3,
    parameter int          NUM_COLORS = 6,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fresh,
    input  logic                        seed_load,
    input  logic [15:0]                 seed_in,
    output logic [ROWS*COLS*CELL_W-1:0] new_board,
    output logic                        if_generated,
    output logic                        busy
);
    localparam int                RW         = $clog2(ROWS);
    localparam int                CW         = $clog2(COLS);
    localparam int                BW         = ROWS * COLS * CELL_W;
    localparam logic [RW-1:0]     ROW_LAST   = RW'(ROWS - 1);
    localparam logic [CW-1:0]     COL_LAST   = CW'(COLS - 1);
    localparam logic [CELL_W-1:0] COLOR_LAST = CELL_W'(NUM_COLORS - 1);
    localparam logic [CELL_W:0]   NC_EXT     = (CELL_W + 1)'(NUM_COLORS);

    typedef enum logic [1:0] {IDLE, DRAW, CHECK, DONE} state_t;

    state_t            state;
    logic [15:0]       lfsr;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic [CELL_W-1:0] cand;
    logic [CELL_W-1:0] work [ROWS][COLS];

    logic [15:0]       lfsr_step;
    logic [CELL_W:0]   raw_ext;
    logic [CELL_W-1:0] drawn;
    logic [CELL_W-1:0] cand_inc;
    logic              last_cell;
    logic [RW-1:0]     r1, r2;
    logic [CW-1:0]     c1, c2;
    logic              illegal;
    logic [BW-1:0]     board_next;

    assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    // Raw code is below 2*NUM_COLORS, so one subtraction folds it into range.
    assign raw_ext   = {1'b0, lfsr[CELL_W-1:0]};
    assign drawn     = (raw_ext >= NC_EXT) ? CELL_W'(raw_ext - NC_EXT) : lfsr[CELL_W-1:0];
    assign cand_inc  = (cand == COLOR_LAST) ? '0 : cand + 1'b1;
    assign last_cell = (row == ROW_LAST) && (col == COL_LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
        c1      = '0;
        c2      = '0;
        r1      = '0;
        r2      = '0;
        illegal = 1'b0;
        if (col >= CW'(2)) begin
            c1      = col - CW'(1);
            c2      = col - CW'(2);
            illegal = (work[row][c1] == cand) && (work[row][c2] == cand);
        end
        if (row >= RW'(2)) begin
            r1      = row - RW'(1);
            r2      = row - RW'(2);
            illegal = illegal || ((work[r1][col] == cand) && (work[r2][col] == cand));
        end
    end

    // The final cell is still in cand on the completing edge, so overlay it.
    always_comb begin
        board_next = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                board_next[(r*COLS+c)*CELL_W +: CELL_W] = work[r][c];
            end
        end
        board_next[(ROWS*COLS-1)*CELL_W +: CELL_W] = cand;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lfsr         <= SEED;
            row          <= '0;
            col          <= '0;
            cand         <= '0;
            new_board    <= '0;
            if_generated <= 1'b0;
            busy         <= 1'b0;
            // NOTE: the work buffer is flop storage and is cleared so an aborted board never leaks into a later one.
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    work[r][c] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (seed_load) begin
                        lfsr <= (seed_in != 16'h0000) ? seed_in : SEED;
                    end else if (fresh) begin
                        row   <= '0;
                        col   <= '0;
                        busy  <= 1'b1;
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    cand  <= drawn;
                    lfsr  <= lfsr_step;
                    state <= CHECK;
                end
                CHECK: begin
                    if (illegal) begin
                        cand <= cand_inc;
                    end else begin
                        work[row][col] <= cand;
                        if (last_cell) begin
                            new_board    <= board_next;
                            if_generated <= 1'b1;
                            busy         <= 1'b0;
                            state        <= DONE;
                        end else begin
                            if (col == COL_LAST) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                            state <= DRAW;
                        end
                    end
                end
                DONE: begin
                    if (!fresh) begin
                        if_generated <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_generator_seq.sv
// Directed bench for board_generator_seq: default 8x8 instance plus a 3x3 two-bit
// instance, checked against a small algorithmic model of the generator.
module tb_board_generator_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         fresh_a, seed_load_a;
    logic [15:0]  seed_in_a;
    logic [191:0] board_a;
    logic         gen_a, busy_a;
    logic         fresh_b, seed_load_b;
    logic [15:0]  seed_in_b;
    logic [17:0]  board_b;
    logic         gen_b, busy_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    board_generator_seq dut_a (
        .clk          (clk),
        .rst          (rst),
        .fresh        (fresh_a),
        .seed_load    (seed_load_a),
        .seed_in      (seed_in_a),
        .new_board    (board_a),
        .if_generated (gen_a),
        .busy         (busy_a)
    );

    board_generator_seq #(.ROWS(3), .COLS(3), .CELL_W(2), .NUM_COLORS(3)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .fresh        (fresh_b),
        .seed_load    (seed_load_b),
        .seed_in      (seed_in_b),
        .new_board    (board_b),
        .if_generated (gen_b),
        .busy         (busy_b)
    );

    task automatic check_vec(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic int cell_of(input logic [191:0] b, input int cols, input int cw,
                                   input int r, input int c);
        logic [191:0] mask;
        mask = (192'(1) << cw) - 192'(1);
        return int'((b >> ((r * cols + c) * cw)) & mask);
    endfunction

    // Count of out-of-range cells plus horizontal/vertical runs of three.
    function automatic int violations(input logic [191:0] b, input int rows, input int cols,
                                      input int cw, input int nc);
        int v = 0;
        int x;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                x = cell_of(b, cols, cw, r, c);
                if (x >= nc) v++;
                if (c >= 2 && cell_of(b, cols, cw, r, c-1) == x && cell_of(b, cols, cw, r, c-2) == x) v++;
                if (r >= 2 && cell_of(b, cols, cw, r-1, c) == x && cell_of(b, cols, cw, r-2, c) == x) v++;
            end
        end
        return v;
    endfunction

    // Reference generator: returns the board and the edge count from the start edge to if_generated.
    task automatic model(input int rows, input int cols, input int cw, input int nc,
                         input logic [15:0] seed, output logic [191:0] board, output int lat);
        logic [15:0] l;
        int          g [8][8];
        int          cand;
        bit          ill;
        l     = seed;
        lat   = 0;
        board = '0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                cand = int'(l) & ((1 << cw) - 1);
                if (cand >= nc) cand = cand - nc;
                l   = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
                lat = lat + 1;
                ill = 1'b1;
                while (ill) begin
                    lat = lat + 1;
                    ill = (c >= 2 && g[r][c-1] == cand && g[r][c-2] == cand) ||
                          (r >= 2 && g[r-1][c] == cand && g[r-2][c] == cand);
                    if (ill) cand = (cand + 1) % nc;
                end
                g[r][c] = cand;
                board   = board | (192'(cand) << ((r * cols + c) * cw));
            end
        end
    endtask

    // Called on a falling edge; raises fresh and counts rising edges until if_generated.
    task automatic run_gen(input bit use_b, input int perturb_at,
                           output logic [191:0] board, output int lat);
        int edges = 0;
        bit done  = 1'b0;
        if (use_b) fresh_b = 1'b1; else fresh_a = 1'b1;
        while (!done && edges < 400) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) check_bit("busy_after_start", use_b ? busy_b : busy_a, 1'b1);
            if (!use_b && perturb_at >= 0) begin
                if (edges == perturb_at) begin
                    seed_load_a = 1'b1;
                    seed_in_a   = 16'h5555;
                end else if (edges == perturb_at + 5) begin
                    seed_load_a = 1'b0;
                end
            end
            done = use_b ? gen_b : gen_a;
        end
        check_bit("done_within_budget", done, 1'b1);
        lat   = edges - 1;
        board = use_b ? {174'b0, board_b} : board_a;
    endtask

    task automatic load_seed(input bit use_b, input logic [15:0] s);
        if (use_b) begin seed_load_b = 1'b1; seed_in_b = s; end
        else       begin seed_load_a = 1'b1; seed_in_a = s; end
        @(negedge clk);
        if (use_b) seed_load_b = 1'b0; else seed_load_a = 1'b0;
    endtask

    task automatic drop(input bit use_b);
        if (use_b) fresh_b = 1'b0; else fresh_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_bit(use_b ? "drop_b" : "drop_a", use_b ? gen_b : gen_a, 1'b0);
    endtask

    initial begin
        logic [191:0] b_def, b_x, b_y, m_x;
        int           lat_def, lat_x, lat_m;
        bit           any_busy;
        logic [15:0]  s;

        rst = 1'b1;
        fresh_a = 1'b0; seed_load_a = 1'b0; seed_in_a = '0;
        fresh_b = 1'b0; seed_load_b = 1'b0; seed_in_b = '0;
        repeat (2) @(negedge clk);
        check_vec("reset_board", board_a, '0);
        check_bit("reset_gen", gen_a, 1'b0);
        check_bit("reset_busy", busy_a, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Default seed
        model(8, 8, 3, 6, 16'hACE1, m_x, lat_m);
        run_gen(1'b0, -1, b_def, lat_def);
        check_vec("default_board", b_def, m_x);
        check_int("default_latency", lat_def, lat_m);
        check_bit("default_latency_range", lat_def >= 128 && lat_def <= 256, 1'b1);
        check_int("default_cell00", cell_of(b_def, 8, 3, 0, 0), 1);
        check_int("default_rules", violations(b_def, 8, 8, 3, 6), 0);

        // fresh held high in DONE must not regenerate
        any_busy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy_a) any_busy = 1'b1;
        end
        check_bit("hold_gen", gen_a, 1'b1);
        check_bit("hold_no_busy", any_busy, 1'b0);
        check_vec("hold_board", board_a, b_def);
        drop(1'b0);
        check_bit("idle_busy", busy_a, 1'b0);

        // Reproducibility with an explicit seed
        load_seed(1'b0, 16'h1234);
        model(8, 8, 3, 6, 16'h1234, m_x, lat_m);
        run_gen(1'b0, -1, b_x, lat_x);
        check_vec("seed1234_board", b_x, m_x);
        check_int("seed1234_latency", lat_x, lat_m);
        drop(1'b0);
        load_seed(1'b0, 16'h1234);
        run_gen(1'b0, -1, b_y, lat_x);
        check_vec("seed1234_repeat", b_y, b_x);
        drop(1'b0);

        load_seed(1'b0, 16'h0001);
        model(8, 8, 3, 6, 16'h0001, m_x, lat_m);
        run_gen(1'b0, -1, b_x, lat_x);
        check_int("seed0001_cell00", cell_of(b_x, 8, 3, 0, 0), 1);
        check_vec("seed0001_board", b_x, m_x);
        drop(1'b0);

        load_seed(1'b0, 16'h0000);
        run_gen(1'b0, -1, b_x, lat_x);
        check_vec("seed0000_is_default", b_x, b_def);
        drop(1'b0);

        // Asynchronous reset in the middle of a generation
        load_seed(1'b0, 16'h1234);
        fresh_a = 1'b1;
        repeat (50) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_vec("midgen_reset_board", board_a, '0);
        check_bit("midgen_reset_busy", busy_a, 1'b0);
        check_bit("midgen_reset_gen", gen_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_gen(1'b0, -1, b_x, lat_x);
        check_vec("after_reset_board", b_x, b_def);
        check_int("after_reset_latency", lat_x, lat_def);
        drop(1'b0);

        // seed_load while busy is ignored
        load_seed(1'b0, 16'hACE1);
        run_gen(1'b0, 10, b_x, lat_x);
        check_vec("seed_load_busy_board", b_x, b_def);
        drop(1'b0);

        // seed_load and fresh together: seed wins, start slips one cycle
        seed_load_a = 1'b1;
        seed_in_a   = 16'h0001;
        fresh_a     = 1'b1;
        @(negedge clk);
        check_bit("load_fresh_delay", busy_a, 1'b0);
        seed_load_a = 1'b0;
        model(8, 8, 3, 6, 16'h0001, m_x, lat_m);
        run_gen(1'b0, -1, b_x, lat_x);
        check_vec("load_fresh_board", b_x, m_x);
        check_int("load_fresh_latency", lat_x, lat_m);
        drop(1'b0);

        // Small configuration across 64 seeds
        for (int i = 0; i < 64; i++) begin
            s = 16'(i * 40503 + 257);
            load_seed(1'b1, s);
            model(3, 3, 2, 3, (s == 16'h0000) ? 16'hACE1 : s, m_x, lat_m);
            run_gen(1'b1, -1, b_x, lat_x);
            check_vec("small_board", b_x, m_x);
            check_int("small_latency", lat_x, lat_m);
            check_bit("small_latency_range", lat_x >= 18 && lat_x <= 36, 1'b1);
            check_int("small_rules", violations(b_x, 3, 3, 2, 3), 0);
            drop(1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/board_generator_seq.md
# board_generator_seq

Clocked, parametrised successor to the combinational board generator: on a `fresh` request it fills a ROWS×COLS board of CELL_W-bit colour codes from a seedable 16-bit LFSR. It rejects any colour that would create a horizontal or vertical run of three, and presents the finished board with an `if_generated` level handshake. It sits between the game controller (issues `fresh`, optional seed) and the board state register / match logic.

## Interface
- ROWS, 8, board rows (≥3)
- COLS, 8, board columns (≥3)
- CELL_W, 3, bits per cell (2..8)
- NUM_COLORS, 6, legal colours 0..NUM_COLORS-1; 2^(CELL_W-1) < NUM_COLORS ≤ 2^CELL_W, NUM_COLORS ≥ 3
- SEED, 16'hACE1, LFSR reset/default value (nonzero)
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- fresh  in  1  level request for a new board
- seed_load  in  1  load `seed_in` into LFSR (IDLE only)
- seed_in  in  16  seed value; 0 loads SEED instead
- new_board  out  ROWS*COLS*CELL_W  board; cell (r,c) at bits [(r*COLS+c)*CELL_W +: CELL_W]
- if_generated  out  1  board valid, handshake acknowledge
- busy  out  1  generation in progress

## Operation
- States: IDLE, DRAW, CHECK, DONE.
- IDLE: seed_load=1 → LFSR ← (seed_in≠0 ? seed_in : SEED); fresh is ignored that cycle. Otherwise, fresh=1 → cell index k←0, go DRAW.
- DRAW: cand ← L[CELL_W-1:0] of current LFSR. If cand ≥ NUM_COLORS, cand ← cand − NUM_COLORS. LFSR steps once. Go CHECK.
- LFSR: Fibonacci, x^16+x^14+x^13+x^11+1. Shift left; new bit0 = b15^b13^b12^b10. Steps only in DRAW.
- CHECK: cand is illegal if (c≥2 and cell(r,c-1)=cell(r,c-2)=cand) or (r≥2 and cell(r-1,c)=cell(r-2,c)=cand).
  - Illegal → cand ← (cand+1) mod NUM_COLORS, stay CHECK.
  - Legal → write cand into the internal work buffer at k.
    - k = ROWS*COLS−1 → copy work buffer to new_board, go DONE.
    - Otherwise k←k+1, go DRAW.
  - At most two colours are excluded, so CHECK resolves in ≤3 cycles.
- DONE: if_generated=1. When fresh=0 → IDLE. fresh held high keeps DONE; no regeneration until fresh drops and rises again.
- busy=1 in DRAW/CHECK only. seed_load is ignored outside IDLE.
- new_board changes only on the edge entering DONE and otherwise holds the last complete board. It never shows a partial board.
- Generation is fully deterministic from the LFSR state at start.

## Timing
- Reset (async, immediate):
  - state=IDLE, LFSR=SEED, k=0
  - new_board=0, work buffer=0, if_generated=0, busy=0
- Reset mid-generation: same, and the partial board is discarded.
- After reset release, the first rising edge with fresh=1 in IDLE starts generation.
- Per cell: 1 DRAW + 1–3 CHECK cycles.
- Latency: from the edge sampling fresh=1 in IDLE to if_generated=1 is between 2·N and 4·N cycles, N=ROWS*COLS. Default config: 128–256.
- if_generated rises on the same edge as new_board updates.
- if_generated falls on the first edge after fresh is sampled low.
- A fresh pulse that deasserts during DRAW/CHECK does not abort. The block still reaches DONE, then returns to IDLE on the next edge.

## Test plan
- Reset: assert rst mid-cycle → all outputs 0 immediately, with no clock edge needed. Release with fresh=1 → busy=1 after the next edge.
- Default seed, fresh=1 until if_generated → cell(0,0)=1 (0xACE1 low bits 001). Every cell < 6. No horizontal or vertical triple anywhere. Latency within 128..256. Drop fresh → if_generated=0 next edge.
- Reproducibility:
  - seed_load with seed_in=16'h1234, generate, capture; repeat → identical board.
  - seed_in=16'h0001 → cell(0,0)=1.
  - seed_in=0 → board identical to the default-seed board.
- Reset mid-generation: assert rst at cycle 50 of generation → new_board=0, busy=0. Regenerate with the default seed → matches the default-seed board.
- Protocol:
  - seed_load asserted while busy → ignored; the board equals the unperturbed run.
  - seed_load and fresh together in IDLE → seed loaded, start delayed one cycle.
  - fresh held high in DONE → no second generation.
- Parameters ROWS=3, COLS=3, CELL_W=2, NUM_COLORS=3 across 64 seeds → every board is triple-free, all cells ≤ 2, and latency is within 18..36.
